// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    // Controller states; encodings are fixed so they read the same in any waveform.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operand/result width used when an instance does not override it.
    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus of the bit-serial adder.
interface serial_adder_if
    import serial_adder_pkg::*;
    #(parameter int WIDTH = DEFAULT_WIDTH);

    logic             start;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output start, operand_a, operand_b, carry_in,
        input  busy, done, sum, carry_out
    );

    modport slave (
        input  start, operand_a, operand_b, carry_in,
        output busy, done, sum, carry_out
    );

endinterface

// File: rtl/serial_adder_shift_register_load.sv
// Gate primitives and the parallel-load / shift-right register used for the operands.

module multiplexer_2to1 (
    input  logic a_i,
    input  logic b_i,
    input  logic sel_i,
    output logic y_o
);
    assign y_o = sel_i ? b_i : a_i;
endmodule

module and_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i & b_i;
endmodule

module or_gate (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i | b_i;
endmodule

module not_gate (
    input  logic a_i,
    output logic y_o
);
    assign y_o = ~a_i;
endmodule

module shift_register_load
    import serial_adder_pkg::*;
    #(parameter int WIDTH = DEFAULT_WIDTH)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             ser_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             ser_o
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] upper_bit;
    logic [WIDTH-1:0] hold_or_shift;

    // Each cell first picks hold vs. shift, then lets a parallel load override it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        if (i == WIDTH - 1) begin : g_top
            assign upper_bit[i] = ser_i;
        end else begin : g_inner
            assign upper_bit[i] = shift_q[i+1];
        end

        multiplexer_2to1 u_shift_mux (
            .a_i   (shift_q[i]),
            .b_i   (upper_bit[i]),
            .sel_i (shift_i),
            .y_o   (hold_or_shift[i])
        );

        multiplexer_2to1 u_load_mux (
            .a_i   (hold_or_shift[i]),
            .b_i   (d_i[i]),
            .sel_i (load_i),
            .y_o   (shift_d[i])
        );
    end

    // Storage flops for every cell, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign ser_o = shift_q[0];

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock through a single full adder and carry flop.
module serial_adder
    import serial_adder_pkg::*;
    #(parameter int WIDTH = DEFAULT_WIDTH)
(
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic             load_en;
    logic             run_en;
    logic             last_bit;

    logic             a_bit;
    logic             b_bit;
    logic             c_q;
    logic             c_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_out_q;
    logic             carry_out_d;

    logic             s_bit;
    logic             c_next;
    logic             not_a;
    logic             not_b;
    logic             not_c;
    logic             not_x;
    logic             a_not_b;
    logic             not_a_b;
    logic             a_xor_b;
    logic             x_not_c;
    logic             not_x_c;
    logic             a_and_b;
    logic             x_and_c;

    shift_register_load #(.WIDTH(WIDTH)) u_a_sr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_en),
        .shift_i (run_en),
        .ser_i   (1'b0),
        .d_i     (bus.operand_a),
        .ser_o   (a_bit)
    );

    shift_register_load #(.WIDTH(WIDTH)) u_b_sr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_en),
        .shift_i (run_en),
        .ser_i   (1'b0),
        .d_i     (bus.operand_b),
        .ser_o   (b_bit)
    );

    // a^b built from and/or/not so the full adder maps onto the primitive cells.
    not_gate u_not_a   (.a_i(a_bit),   .y_o(not_a));
    not_gate u_not_b   (.a_i(b_bit),   .y_o(not_b));
    and_gate u_a_nb    (.a_i(a_bit),   .b_i(not_b), .y_o(a_not_b));
    and_gate u_na_b    (.a_i(not_a),   .b_i(b_bit), .y_o(not_a_b));
    or_gate  u_a_xor_b (.a_i(a_not_b), .b_i(not_a_b), .y_o(a_xor_b));

    // Sum bit = (a^b)^c.
    not_gate u_not_x   (.a_i(a_xor_b), .y_o(not_x));
    not_gate u_not_c   (.a_i(c_q),     .y_o(not_c));
    and_gate u_x_nc    (.a_i(a_xor_b), .b_i(not_c), .y_o(x_not_c));
    and_gate u_nx_c    (.a_i(not_x),   .b_i(c_q),   .y_o(not_x_c));
    or_gate  u_sum     (.a_i(x_not_c), .b_i(not_x_c), .y_o(s_bit));

    // Carry = a&b | c&(a^b), which equals the majority of the three inputs.
    and_gate u_a_b     (.a_i(a_bit),   .b_i(b_bit), .y_o(a_and_b));
    and_gate u_x_c     (.a_i(a_xor_b), .b_i(c_q),   .y_o(x_and_c));
    or_gate  u_carry   (.a_i(a_and_b), .b_i(x_and_c), .y_o(c_next));

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus load/shift strobes; start is only honoured outside RUN.
    always_comb begin
        state_d = state_q;
        load_en = 1'b0;
        run_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load_en = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run_en = 1'b1;
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    load_en = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    always_comb begin
        c_d         = c_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        if (load_en) begin
            c_d   = bus.carry_in;
            cnt_d = '0;
        end else if (run_en) begin
            c_d   = c_next;
            sum_d = {s_bit, sum_q[WIDTH-1:1]};
            if (last_bit) begin
                carry_out_d = c_next;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Carry, bit counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q         <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;

endmodule
